// File: rtl/delay_chain_prober.sv
// delay_chain_prober: launches a 0->1 step into a delay-chain array and records per-lane arrival latency.
// Optional PROBE_SKEW_EN adds registered lat_min/lat_max/skew over arrived lanes.
module delay_chain_prober #(
  parameter int LANES   = 8,
  parameter int CNT_W   = 12,
  parameter int MAX_CYC = 2047
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LANES-1:0]       chain_in,
  output logic [LANES-1:0]       probe_out,
  output logic                   busy,
  output logic                   done,
  output logic [LANES-1:0]       arrived,
  output logic                   timeout,
  output logic                   stuck,
  output logic [LANES*CNT_W-1:0] lat
`ifdef PROBE_SKEW_EN
  ,
  output logic [CNT_W-1:0]       lat_min,
  output logic [CNT_W-1:0]       lat_max,
  output logic [CNT_W-1:0]       skew
`endif
);
  typedef enum logic [1:0] {IDLE, FLUSH, MEASURE, DONE} state_t;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_CYC);
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LANES-1:0]       probe_q, probe_d, arr_q, arr_d;
  logic                   to_q, to_d, stuck_q, stuck_d;
  logic [LANES*CNT_W-1:0] lat_q, lat_d;
  logic [LANES-1:0]       hit;
  assign hit = chain_in & ~arr_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    probe_d = probe_q;
    arr_d   = arr_q;
    to_d    = to_q;
    stuck_d = stuck_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        probe_d = '0;
        if (start) begin
          state_d = FLUSH;
          cnt_d   = '0;
          arr_d   = '0;
          to_d    = 1'b0;
          stuck_d = 1'b0;
          lat_d   = '1;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MAX - 1'b1) begin
          if (|chain_in) begin
            state_d = DONE;
            stuck_d = 1'b1;
          end else begin
            state_d = MEASURE;
            probe_d = '1;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      MEASURE: begin
        // only the first rising sample of each lane is recorded
        for (int i = 0; i < LANES; i++)
          if (hit[i]) lat_d[i*CNT_W +: CNT_W] = cnt_q;
        arr_d = arr_q | chain_in;
        cnt_d = (cnt_q == MAX) ? cnt_q : cnt_q + 1'b1;
        if (&arr_d) state_d = DONE;
        else if (cnt_q == MAX) begin
          state_d = DONE;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        probe_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      probe_q <= '0;
      arr_q   <= '0;
      to_q    <= 1'b0;
      stuck_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      probe_q <= probe_d;
      arr_q   <= arr_d;
      to_q    <= to_d;
      stuck_q <= stuck_d;
      lat_q   <= lat_d;
    end
  end
  assign probe_out = probe_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign arrived   = arr_q;
  assign timeout   = to_q;
  assign stuck     = stuck_q;
  assign lat       = lat_q;
`ifdef PROBE_SKEW_EN
  logic [CNT_W-1:0] mn_d, mx_d, mn_q, mx_q, sk_q;
  always_comb begin
    mn_d = '1;
    mx_d = '0;
    for (int i = 0; i < LANES; i++)
      if (arr_d[i]) begin
        mn_d = (lat_d[i*CNT_W +: CNT_W] < mn_d) ? lat_d[i*CNT_W +: CNT_W] : mn_d;
        mx_d = (lat_d[i*CNT_W +: CNT_W] > mx_d) ? lat_d[i*CNT_W +: CNT_W] : mx_d;
      end
    mn_d = (arr_d == '0) ? '0 : mn_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mn_q <= '0;
      mx_q <= '0;
      sk_q <= '0;
    end else if (state_d == DONE) begin
      mn_q <= mn_d;
      mx_q <= mx_d;
      sk_q <= mx_d - mn_d;
    end
  end
  assign lat_min = mn_q;
  assign lat_max = mx_q;
  assign skew    = sk_q;
`endif
endmodule

// File: tb/tb_delay_chain_prober.sv
// tb_delay_chain_prober: drives a modelled delay-chain array and checks latencies against expected arrival times.
module tb_delay_chain_prober;
  localparam int LANES = 8, CNT_W = 12, MAX_CYC = 31;
  localparam logic [CNT_W-1:0] ONES = '1;
  logic clk = 1'b0, rst, start;
  logic [LANES-1:0] chain_in, probe_out, arrived;
  logic busy, done, timeout, stuck;
  logic [LANES*CNT_W-1:0] lat;
`ifdef PROBE_SKEW_EN
  logic [CNT_W-1:0] lat_min, lat_max, skew;
  logic [CNT_W-1:0] exp_min, exp_max;
`endif
  int pass = 0, total = 0;
  int mode [LANES];
  int dly [LANES];
  logic [LANES-1:0] hist [32];
  logic [LANES-1:0] exp_arr;
  logic exp_to, exp_stuck;
  logic [CNT_W-1:0] exp_lat [LANES];
  int exp_n;

  always #5 clk = ~clk;

  delay_chain_prober #(.LANES(LANES), .CNT_W(CNT_W), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .chain_in(chain_in), .probe_out(probe_out),
    .busy(busy), .done(done), .arrived(arrived), .timeout(timeout), .stuck(stuck), .lat(lat)
`ifdef PROBE_SKEW_EN
    , .lat_min(lat_min), .lat_max(lat_max), .skew(skew)
`endif
  );

  // chain model: mode 0 = dly-register shift, 1 = tied low, 2 = tied high, 3 = one-cycle pulse after dly registers
  always @(posedge clk) begin
    if (rst) for (int k = 0; k < 32; k++) hist[k] <= '0;
    else begin
      for (int k = 31; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= probe_out;
    end
  end
  always_comb begin
    chain_in = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mode[i] == 0) chain_in[i] = (dly[i] == 0) ? probe_out[i] : hist[dly[i]-1][i];
      else if (mode[i] == 2) chain_in[i] = 1'b1;
      else if (mode[i] == 3) chain_in[i] = ((dly[i] == 0) ? probe_out[i] : hist[dly[i]-1][i]) & ~hist[dly[i]][i];
    end
  end

  task automatic model();
    int mx;
    bit all;
    exp_stuck = 1'b0;
    exp_arr = '0;
    exp_to = 1'b0;
    mx = 0;
    all = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      exp_lat[i] = ONES;
      if (mode[i] == 2) exp_stuck = 1'b1;
    end
    if (exp_stuck) exp_n = MAX_CYC;
    else begin
      for (int i = 0; i < LANES; i++)
        if ((mode[i] == 0 || mode[i] == 3) && dly[i] + 1 <= MAX_CYC) begin
          exp_arr[i] = 1'b1;
          exp_lat[i] = CNT_W'(dly[i] + 1);
          if (dly[i] + 1 > mx) mx = dly[i] + 1;
        end else all = 1'b0;
      exp_to = !all;
      exp_n = MAX_CYC + (all ? mx : MAX_CYC);
    end
`ifdef PROBE_SKEW_EN
    exp_min = '0;
    exp_max = '0;
    if (exp_arr != '0) begin
      exp_min = ONES;
      for (int i = 0; i < LANES; i++)
        if (exp_arr[i]) begin
          if (exp_lat[i] < exp_min) exp_min = exp_lat[i];
          if (exp_lat[i] > exp_max) exp_max = exp_lat[i];
        end
    end
`endif
  endtask

  task automatic run(input string name, input bit mid_start, input bit b2b);
    int n;
    bit seen;
    model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    seen = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL %s busy_after_start got %b exp 1", name, busy); else pass++;
    while (done !== 1'b1 && n < 4*MAX_CYC) begin
      @(negedge clk);
      n++;
      if (probe_out != '0) seen = 1'b1;
      start = mid_start && (n == 3 || n == MAX_CYC + 2);
    end
    start = 1'b0;
    total++; if (n !== exp_n) $display("FAIL %s done_cycle got %0d exp %0d", name, n, exp_n); else pass++;
    total++; if (arrived !== exp_arr) $display("FAIL %s arrived got %h exp %h", name, arrived, exp_arr); else pass++;
    total++; if (timeout !== exp_to) $display("FAIL %s timeout got %b exp %b", name, timeout, exp_to); else pass++;
    total++; if (stuck !== exp_stuck) $display("FAIL %s stuck got %b exp %b", name, stuck, exp_stuck); else pass++;
    total++; if (seen !== !exp_stuck) $display("FAIL %s probe_rose got %b exp %b", name, seen, !exp_stuck); else pass++;
    for (int i = 0; i < LANES; i++) begin
      total++;
      if (lat[i*CNT_W +: CNT_W] !== exp_lat[i]) $display("FAIL %s lat[%0d] got %0d exp %0d", name, i, lat[i*CNT_W +: CNT_W], exp_lat[i]);
      else pass++;
    end
`ifdef PROBE_SKEW_EN
    total++; if (lat_min !== exp_min) $display("FAIL %s lat_min got %0d exp %0d", name, lat_min, exp_min); else pass++;
    total++; if (lat_max !== exp_max) $display("FAIL %s lat_max got %0d exp %0d", name, lat_max, exp_max); else pass++;
    total++; if (skew !== exp_max - exp_min) $display("FAIL %s skew got %0d exp %0d", name, skew, exp_max - exp_min); else pass++;
`endif
    if (b2b) start = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || probe_out !== '0)
      $display("FAIL %s idle_after_done got busy=%b done=%b probe=%h exp 0 0 00", name, busy, done, probe_out);
    else pass++;
  endtask

  task automatic set_all(input int m, input int d);
    for (int i = 0; i < LANES; i++) begin
      mode[i] = m;
      dly[i] = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    set_all(0, 0);
    repeat (3) @(negedge clk);
    total++; if (probe_out !== '0) $display("FAIL reset probe_out got %h exp 0", probe_out); else pass++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset busy_done got %b%b exp 00", busy, done); else pass++;
    total++; if (arrived !== '0 || timeout !== 1'b0 || stuck !== 1'b0) $display("FAIL reset flags got %h %b %b exp 0 0 0", arrived, timeout, stuck); else pass++;
    total++; if (lat !== '0) $display("FAIL reset lat got %h exp 0", lat); else pass++;
`ifdef PROBE_SKEW_EN
    total++; if (lat_min !== '0 || lat_max !== '0 || skew !== '0) $display("FAIL reset skew got %0d %0d %0d exp 0 0 0", lat_min, lat_max, skew); else pass++;
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    set_all(0, 0);
    run("loopback", 1'b0, 1'b0);
  endtask

  task automatic test_shift_chains();
    for (int i = 0; i < LANES; i++) begin
      mode[i] = 0;
      dly[i] = (i + 1) * 3;
    end
    run("shift_chains", 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    set_all(0, 0);
    mode[5] = 1;
    run("timeout_lane5", 1'b0, 1'b0);
  endtask

  task automatic test_stuck();
    set_all(0, 0);
    mode[2] = 2;
    run("stuck_lane2", 1'b0, 1'b0);
  endtask

  task automatic test_boundary();
    set_all(0, 0);
    dly[3] = MAX_CYC - 1;
    mode[6] = 3;
    dly[6] = 4;
    run("arrive_at_limit", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_all(3, 2);
    run("b2b_first", 1'b0, 1'b1);
    set_all(0, 5);
    run("b2b_second", 1'b0, 1'b0);
  endtask

  task automatic test_skew_pattern();
    for (int i = 0; i < LANES; i++) begin
      mode[i] = 0;
      dly[i] = 2 * i + 1;
    end
    run("skew_even", 1'b0, 1'b0);
    set_all(1, 0);
    run("all_low", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cnt;
    set_all(0, 20);
    dly[0] = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (MAX_CYC + 5) @(negedge clk);
    total++; if (busy !== 1'b1 || probe_out !== '1) $display("FAIL mid_run_measuring got busy=%b probe=%h exp 1 ff", busy, probe_out); else pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0 || probe_out !== '0) $display("FAIL mid_reset_state got busy=%b probe=%h exp 0 00", busy, probe_out); else pass++;
    total++; if (lat !== '0 || arrived !== '0) $display("FAIL mid_reset_results got lat=%h arr=%h exp 0 0", lat, arrived); else pass++;
    cnt = 0;
    repeat (MAX_CYC + 4) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt++;
    end
    total++; if (cnt !== 0) $display("FAIL mid_reset_no_rerun got %0d busy cycles exp 0", cnt); else pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < LANES; i++) begin
        int p;
        p = int'($urandom_range(0, 39));
        dly[i] = int'($urandom_range(0, MAX_CYC - 1));
        mode[i] = (p < 31) ? 0 : (p < 36) ? 3 : (p < 38) ? 1 : 2;
      end
      run($sformatf("random%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_shift_chains();
    test_timeout();
    test_stuck();
    test_boundary();
    test_back_to_back();
    test_skew_pattern();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
